// File: rtl/printer_engine.sv
// Printer-side peripheral: accepts strobed bytes into a small FIFO, prints each one
// for a fixed number of cycles, then presents it on a valid/ack output port.
module printer_engine #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRINT_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       print_data,
  input  logic             pulse_request,
  output logic             print_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ack,
  output logic             busy,
  output logic             overrun_err,
  output logic [CNT_W-1:0] char_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CYC_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(PRINT_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRINT, S_PRESENT} state_t;

  state_t           state_q, state_d;
  logic             pulse_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cur_byte_q, cur_byte_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             print_ready_q, print_ready_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] char_count_q, char_count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             strobe, push, pop;

  always_comb begin
    strobe        = pulse_request & ~pulse_q;
    push          = strobe & print_ready_q;
    pop           = (state_q == S_IDLE) && (count_q != '0);
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    cur_byte_d    = cur_byte_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    overrun_d     = overrun_q;
    char_count_d  = char_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    // Ready looks ahead at the post-edge occupancy so a full FIFO is never pushed.
    print_ready_d = (count_d < DEPTH_C);
    if (strobe && !print_ready_q) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_byte_d = mem_q[rd_ptr_q];
          cnt_d      = CYC_LOAD;
          state_d    = S_PRINT;
        end
      end
      S_PRINT: begin
        if (cnt_q == '0) begin
          state_d     = S_PRESENT;
          out_valid_d = 1'b1;
          out_data_d  = cur_byte_q;
        end else begin
          cnt_d = cnt_q - CYC_W'(1);
        end
      end
      S_PRESENT: begin
        if (out_ack) begin
          out_valid_d  = 1'b0;
          char_count_d = char_count_q + CNT_W'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (count_d != '0) | (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pulse_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cnt_q         <= '0;
      cur_byte_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      print_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      char_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      pulse_q       <= pulse_request;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cnt_q         <= cnt_d;
      cur_byte_q    <= cur_byte_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      print_ready_q <= print_ready_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      char_count_q  <= char_count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= print_data;
  end

  assign print_ready = print_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign overrun_err = overrun_q;
  assign char_count  = char_count_q;

endmodule
